// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package uart_tx_pkg;

   // Register offsets within the block's word-address window
   localparam logic [22:0] OFF_TXDATA = 23'd0;
   localparam logic [22:0] OFF_STATUS = 23'd1;

   // STATUS register bit positions
   localparam int ST_BUSY   = 0;
   localparam int ST_FULL   = 1;
   localparam int ST_EMPTY  = 2;
   localparam int ST_OVF    = 3;
   localparam int ST_CNT_LO = 4;
   localparam int ST_CNT_W  = 5;

   // Transmit state machine states
   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus slice seen by the UART: strobe, address, write data, byte enables, read data.
interface uart_tx_mmio_if;
   logic        en;
   logic [31:0] addr;
   logic [31:0] d;
   logic [3:0]  we;
   logic [31:0] q;

   modport master (output en, output addr, output d, output we, input q);
   modport slave  (input en, input addr, input d, input we, output q);
endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted when a pop frees space on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // Qualify requests and compute next pointer and occupancy values
   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Pointer and occupancy registers, cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, STATUS mux, registered read data, TX FSM.
module uart_tx_mmio
   import uart_tx_pkg::*;
#(
   parameter logic [8:0] BASE         = 9'h002,
   parameter int         CLKS_PER_BIT = 868,
   parameter int         FIFO_DEPTH   = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_tx_mmio_if.slave  bus,
   output logic           txd
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   tx_state_e          state_q, state_d;
   logic [BAUD_W-1:0]  baud_q, baud_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic [7:0]         shift_q, shift_d;
   logic               txd_q, txd_d;
   logic               overflow_q, overflow_d;
   logic [31:0]        q_q, q_d;

   logic               sel;
   logic [22:0]        offset;
   logic               push_req;
   logic               clr_ovf;
   logic               fifo_push;
   logic               fifo_pop;
   logic [7:0]         fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic [ST_CNT_W-1:0] cnt_field;
   logic               busy;
   logic [31:0]        status_word;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (bus.d[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign busy  = (state_q != IDLE);
   assign txd   = txd_q;
   assign bus.q = q_q;

   // Decode the bus access, build the STATUS word and next read-data/overflow values
   always_comb begin
      sel       = bus.en && (bus.addr[31:23] == BASE);
      offset    = bus.addr[22:0];
      push_req  = sel && (offset == OFF_TXDATA) && bus.we[0];
      clr_ovf   = sel && (offset == OFF_STATUS) && bus.we[0] && bus.d[ST_OVF];
      fifo_push = push_req && (!fifo_full || fifo_pop);

      if (32'(fifo_count) > 31) begin
         cnt_field = 5'd31;
      end else begin
         cnt_field = 5'(fifo_count);
      end

      status_word            = '0;
      status_word[ST_BUSY]   = busy;
      status_word[ST_FULL]   = fifo_full;
      status_word[ST_EMPTY]  = fifo_empty;
      status_word[ST_OVF]    = overflow_q;
      status_word[ST_CNT_LO +: ST_CNT_W] = cnt_field;

      q_d = q_q;
      if (sel) begin
         q_d = (offset == OFF_STATUS) ? status_word : 32'h0;
      end

      overflow_d = overflow_q;
      if (push_req && fifo_full && !fifo_pop) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end
   end

   // Transmit FSM next state; txd is derived from the next state so it changes on the transition edge
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      fifo_pop  = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
               baud_d   = '0;
               state_d  = START;
            end
         end
         START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d    = '0;
               bit_idx_d = 3'd0;
               state_d   = DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dout;
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
         end
      endcase

      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   // State, datapath and bus registers; reset aborts any frame and forces the line high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'h00;
         txd_q      <= 1'b1;
         overflow_q <= 1'b0;
         q_q        <= 32'h0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         txd_q      <= txd_d;
         overflow_q <= overflow_d;
         q_q        <= q_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio with a frame-level reference model.
module tb_uart_tx_mmio;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic clk;
   logic rst_n;
   logic txd;

   uart_tx_mmio_if bus ();

   uart_tx_mmio #(
      .BASE         (9'h002),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .txd   (txd)
   );

   int nvec = 0;
   int nerr = 0;
   bit chk_en = 0;

   // Reference model state: queued bytes, frame in flight and its cycle position
   logic [7:0]  mq[$];
   bit          active;
   int          t;
   logic [7:0]  cur;
   bit          ovf;
   logic [31:0] q_exp;
   logic        txd_exp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s = 32'h0;
      s[8:4] = 5'(mq.size());
      s[3]   = ovf;
      s[2]   = (mq.size() == 0);
      s[1]   = (mq.size() == DEPTH);
      s[0]   = active;
      return s;
   endfunction

   function automatic logic frame_bit();
      int k;
      k = t / CPB;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return cur[k-1];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model advance per clock edge, using pre-edge state and the inputs the bench holds
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         active  = 0;
         t       = 0;
         cur     = 8'h00;
         ovf     = 0;
         q_exp   = 32'h0;
         txd_exp = 1'b1;
      end else begin
         bit          sel;
         bit          pop;
         int          n;
         logic [31:0] st;
         logic [22:0] off;
         sel = bus.en && (bus.addr[31:23] == 9'h002);
         off = bus.addr[22:0];
         st  = model_status();
         n   = mq.size();
         pop = (n > 0) && (!active || t == FRAME - 1);
         if (sel) q_exp = (off == 23'd1) ? st : 32'h0;
         if (pop) begin
            cur    = mq.pop_front();
            active = 1;
            t      = 0;
         end else if (active) begin
            if (t == FRAME - 1) active = 0;
            else t++;
         end
         if (sel && off == 23'd0 && bus.we[0]) begin
            if (n < DEPTH || pop) mq.push_back(bus.d[7:0]);
            else ovf = 1;
         end
         if (sel && off == 23'd1 && bus.we[0] && bus.d[3]) ovf = 0;
         txd_exp = active ? frame_bit() : 1'b1;
      end
   end

   // Every-cycle comparison of DUT outputs against the model, away from the active edge
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         checkOutput("txd", {31'b0, txd}, {31'b0, txd_exp});
         checkOutput("q", bus.q, q_exp);
      end
   end

   // Drive one bus cycle (called just after a falling edge) and return after the next falling edge
   task automatic applyStimulus(input logic en, input logic [31:0] addr, input logic [31:0] d,
                                input logic [3:0] we);
      bus.en   = en;
      bus.addr = addr;
      bus.d    = d;
      bus.we   = we;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   task automatic writeTx(input logic [7:0] b);
      applyStimulus(1'b1, 32'h0100_0000, {24'h0, b}, 4'h1);
   endtask

   task automatic readStatus();
      applyStimulus(1'b1, 32'h0100_0001, 32'h0, 4'h0);
   endtask

   initial begin
      int guard;
      logic [9:0] pat;
      rst_n    = 1'b0;
      bus.en   = 1'b0;
      bus.addr = 32'h0;
      bus.d    = 32'h0;
      bus.we   = 4'h0;
      repeat (3) @(negedge clk);
      checkOutput("reset_txd", {31'b0, txd}, 32'h1);
      checkOutput("reset_q", bus.q, 32'h0);
      rst_n  = 1'b1;
      chk_en = 1;

      // Status after reset
      readStatus();
      checkOutput("status_after_reset", bus.q, 32'h004);

      // Single byte 0x55
      pat = 10'b1010101010;
      writeTx(8'h55);
      checkOutput("single_pre_start", {31'b0, txd}, 32'h1);
      for (int i = 0; i < FRAME; i++) begin
         idle(1);
         checkOutput($sformatf("single_bit%0d", i), {31'b0, txd}, {31'b0, pat[i / CPB]});
      end
      idle(1);
      checkOutput("single_line_idle", {31'b0, txd}, 32'h1);
      readStatus();
      checkOutput("status_after_single", bus.q, 32'h004);

      // Asynchronous reset in the middle of a frame
      writeTx(8'h33);
      idle(3);
      readStatus();
      checkOutput("status_mid_frame", bus.q, 32'h005);
      idle(3);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("async_reset_txd", {31'b0, txd}, 32'h1);
      checkOutput("async_reset_q", bus.q, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      readStatus();
      checkOutput("status_after_async_reset", bus.q, 32'h004);

      // Burst of five back-to-back writes; first pops at once, remaining four fill the FIFO
      for (int i = 1; i <= 5; i++) writeTx(8'(i));
      readStatus();
      checkOutput("status_after_burst", bus.q, 32'h043);

      // Overflow: FIFO full, byte in shift register, no pop on this edge
      writeTx(8'hAA);
      readStatus();
      checkOutput("status_overflow", bus.q, 32'h04B);
      applyStimulus(1'b1, 32'h0100_0001, 32'h8, 4'h1);
      readStatus();
      checkOutput("status_ovf_cleared", bus.q, 32'h043);

      // Decode: RAM window read leaves q alone, offset 2 write is ignored
      applyStimulus(1'b1, 32'h0080_0001, 32'h0, 4'h0);
      checkOutput("ram_window_q_hold", bus.q, 32'h043);
      applyStimulus(1'b1, 32'h0100_0002, 32'hFFFF_FFFF, 4'hF);
      checkOutput("offset2_q", bus.q, 32'h0);
      readStatus();
      checkOutput("status_after_offset2", bus.q, 32'h043);

      // Push on the edge where STOP ends with the FIFO full
      guard = 0;
      while (!(active && t == FRAME - 1 && mq.size() == DEPTH) && guard < 200) begin
         idle(1);
         guard++;
      end
      checkOutput("popfull_wait_timeout", {31'b0, (guard >= 200)}, 32'h0);
      writeTx(8'h77);
      readStatus();
      checkOutput("status_push_on_pop", bus.q, 32'h043);

      // Randomized traffic across windows and offsets
      for (int i = 0; i < 400; i++) begin
         int          r;
         int          k;
         logic [8:0]  base;
         logic [22:0] off;
         r = $urandom_range(0, 9);
         if (r < 7) base = 9'h002;
         else if (r == 7) base = 9'h001;
         else base = 9'($urandom);
         k = $urandom_range(0, 9);
         if (k < 6) off = 23'd0;
         else if (k < 9) off = 23'd1;
         else off = 23'($urandom_range(2, 100));
         applyStimulus(($urandom_range(0, 3) != 0), {base, off}, $urandom,
                       4'($urandom_range(0, 15)));
      end

      // Drain and confirm the line returns to idle
      idle(FRAME * (DEPTH + 2));
      readStatus();
      checkOutput("status_drained", bus.q & 32'hFFFF_FFF7, 32'h004);
      checkOutput("txd_drained", {31'b0, txd}, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
